sync_tx_sched: RTL and testbench
================================

Name: sync_tx_sched

Overview:
- Transmit-side scheduler for the single-bit sync_ff synchronizer channel, running in the clk_tx domain.
- Arbitrates round-robin among N_REQ requesters, each offering a DATA_W-bit message.
- Drives a bundled-data toggle handshake: holds the payload stable, flips sync_din, then waits for the synchronized acknowledge toggle returned from the clk_rx side.
- Sits between local requesters and the sync_ff instance; the receive side samples tx_data once it sees the toggle.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_W, 8, payload width per requester
TIMEOUT, 64, max WAIT_ACK cycles before abort (>=4)
GAP, 2, idle cycles enforced after each ack before next arbitration (>=0)

Ports:
clk_tx  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
req  in  N_REQ  per-requester request level; held until grant
req_data  in  N_REQ*DATA_W  payload; slice i = req_data[i*DATA_W +: DATA_W]
grant  out  N_REQ  one-hot, one-cycle pulse when request i is accepted
tx_data  out  DATA_W  payload to receive side; stable from accept until ack/abort
tx_id  out  IDW  index of the accepted requester; IDW = max(1, clog2(N_REQ))
sync_din  out  1  request toggle; connects to synchronizer din
sync_ack  in  1  acknowledge toggle, already synchronized into clk_tx
busy  out  1  high from accept through end of GAP
err_timeout  out  1  sticky abort flag
err_clr  in  1  clears err_timeout

Behaviour:
- Clock and reset: one clock, clk_tx. rst is synchronous and active-high.
- Reset values:
  - sync_din=0, tx_data=0, tx_id=0, grant=0, busy=0, err_timeout=0.
  - Round-robin pointer=0, state=IDLE, counters=0.
- States: IDLE, WAIT_ACK, SETTLE.
- IDLE:
  - In cycle T, if req!=0, select the first set bit at or after the pointer, wrapping around.
  - At edge T+1: grant[i]=1 for exactly one cycle, tx_data<=slice i, tx_id<=i, sync_din<=~sync_din, busy<=1, pointer<=(i+1) mod N_REQ, state<=WAIT_ACK, timeout counter<=0.
  - req==0: remain in IDLE, no output change.
- WAIT_ACK:
  - tx_data, tx_id and sync_din are held.
  - When sync_ack==sync_din: state<=SETTLE, gap counter<=0.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 without ack: err_timeout<=1, sync_din<=sync_ack (abandon phase, so the next transfer cannot see a false ack), state<=SETTLE.
- SETTLE:
  - Counts GAP cycles, then state<=IDLE and busy<=0.
  - GAP=0: go to IDLE on the next edge.
  - Earliest re-arbitration is in the first IDLE cycle.
- Latency: req asserted in cycle T while IDLE and pointer-eligible gives grant and toggle at T+1.
- Back-to-back throughput: 1 (accept) + ack round-trip + (GAP+1) cycles.
- Simultaneous requests: exactly one grant per transaction. A requester is granted again only after every other active requester has been granted once.
- A requester dropping req:
  - Before arbitration samples it: not serviced.
  - In the sampling cycle itself: still granted.
- sync_ack changes while in IDLE or SETTLE: ignored.
- An ack arriving in the same cycle the timeout would fire takes priority; no error is raised.
- err_timeout:
  - Set has priority over err_clr in the same cycle.
  - Sticky otherwise.
  - Does not block further transfers.
- rst asserted mid-transfer: all state returns to reset values on that edge, including sync_din=0. The receive side must also be reset.
- grant is never asserted while busy was high in the previous cycle.

Decomposition:
- Package sync_sched_pkg:
  - state enum (IDLE, WAIT_ACK, SETTLE).
  - IDW computation function.
  - Timeout and gap counter width helpers.
- Sub-module rr_arbiter (N_REQ parameter):
  - Inputs: req, pointer, enable.
  - Outputs: one-hot select, select index, valid.
  - Purely combinational priority rotation.
- All sequencing stays in sync_tx_sched.

Test Plan:
- Reset, then req=4'b0001, data0=8'hA5, ack looped back after 3 cycles:
  - grant=0001 one cycle after req; sync_din 0->1; tx_data=A5, tx_id=0 held until ack.
  - busy falls GAP+1 cycles after ack.
- req=4'b1111 held continuously, ack auto-returned:
  - Grant order 0,1,2,3,0,1.
  - tx_id follows the same order; sync_din alternates each transfer.
- Pointer=2 after granting 1, then req=4'b0011:
  - Next grant is 0, then 1.
- Ack never returned, TIMEOUT=64:
  - err_timeout rises exactly 64 cycles after the toggle; sync_din reverts to the sync_ack value.
  - Next transfer completes normally with err_timeout still 1.
  - err_clr clears it.
- Ack arriving on the same cycle as timeout expiry:
  - err_timeout stays 0 and state goes to SETTLE.
- rst pulsed during WAIT_ACK with sync_din=1:
  - Next cycle sync_din=0, busy=0, grant=0, pointer=0.
  - A pending req then gets granted one cycle after rst deasserts.

Source files
------------

// File: rtl/sync_sched_pkg.sv
// Shared types and width helpers for the sync_tx_sched transmit scheduler.
package sync_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAck,
    StSettle
  } state_e;

  // Width of a requester index: max(1, clog2(n)).
  function automatic int unsigned calc_idw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold values 0..n-1 (at least 1 bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_tx_sched_if.sv
// Requester and synchronizer-side signals of the transmit scheduler.
interface sync_tx_sched_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
);
  import sync_sched_pkg::*;

  localparam int unsigned IDW = calc_idw(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        grant;
  logic [DATA_W-1:0]       tx_data;
  logic [IDW-1:0]          tx_id;
  logic                    sync_din;
  logic                    sync_ack;
  logic                    busy;
  logic                    err_timeout;
  logic                    err_clr;

  // Requester / environment side.
  modport master (
    output req, req_data, sync_ack, err_clr,
    input  grant, tx_data, tx_id, sync_din, busy, err_timeout
  );

  // Scheduler side.
  modport slave (
    input  req, req_data, sync_ack, err_clr,
    output grant, tx_data, tx_id, sync_din, busy, err_timeout
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import sync_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDW  = calc_idw(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] sel,
  output logic [IDW-1:0]   idx,
  output logic             valid
);

  logic           hi_found;
  logic           lo_found;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;

  // Lowest set index at/above ptr wins; otherwise wrap to the lowest set index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
        if (IDW'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    valid = enable & lo_found;
    idx   = hi_found ? hi_idx : lo_idx;
    sel   = '0;
    if (valid) sel[idx] = 1'b1;
  end

endmodule

// File: rtl/sync_tx_sched.sv
// Transmit-side scheduler: round-robin accept, toggle handshake, ack timeout, idle gap.
module sync_tx_sched
  import sync_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned GAP     = 2
) (
  input logic            clk_tx,
  input logic            rst,
  sync_tx_sched_if.slave bus
);

  localparam int unsigned IDW = calc_idw(N_REQ);
  localparam int unsigned TW  = cnt_w(TIMEOUT);
  localparam int unsigned GW  = cnt_w(GAP + 1);

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDW-1:0]    id_q, id_d;
  logic              din_q, din_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]  arb_sel;
  logic [IDW-1:0]    arb_idx;
  logic              arb_valid;
  logic              arb_en;

  assign arb_en = (state_q == StIdle);

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req    (bus.req),
    .ptr    (ptr_q),
    .enable (arb_en),
    .sel    (arb_sel),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  // Next-state and output sequencing.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    grant_d = '0;
    data_d  = data_q;
    id_d    = id_q;
    din_d   = din_q;
    busy_d  = busy_q;
    err_d   = err_q;

    // Clear first so a timeout in the same cycle wins.
    if (bus.err_clr) err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d = arb_sel;
          id_d    = arb_idx;
          din_d   = ~din_q;
          busy_d  = 1'b1;
          tcnt_d  = '0;
          state_d = StWaitAck;
          ptr_d   = (arb_idx == IDW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          for (int i = 0; i < int'(N_REQ); i++) begin
            if (arb_sel[i]) data_d = bus.req_data[i*DATA_W +: DATA_W];
          end
        end
      end
      StWaitAck: begin
        if (bus.sync_ack == din_q) begin
          state_d = StSettle;
          gcnt_d  = '0;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          // Re-align phase with the ack so a late ack is not taken as the next one.
          err_d   = 1'b1;
          din_d   = bus.sync_ack;
          state_d = StSettle;
          gcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StSettle: begin
        if (gcnt_q == GW'(GAP)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_tx) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      grant_q <= '0;
      data_q  <= '0;
      id_q    <= '0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      id_q    <= id_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.tx_data     = data_q;
  assign bus.tx_id       = id_q;
  assign bus.sync_din    = din_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_sync_tx_sched.sv
// Directed bench for sync_tx_sched (N_REQ=4, DATA_W=8, TIMEOUT=64, GAP=2).
module tb_sync_tx_sched;

  logic       clk_tx;
  logic       rst;
  logic       ack_auto;
  logic       ack_man;
  logic [2:0] pipe;
  int         total;
  int         bad;
  int         n;

  sync_tx_sched_if #(.N_REQ(4), .DATA_W(8)) bus ();

  sync_tx_sched #(
    .N_REQ   (4),
    .DATA_W  (8),
    .TIMEOUT (64),
    .GAP     (2)
  ) dut (
    .clk_tx (clk_tx),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk_tx = 1'b0;
  always #5 clk_tx = ~clk_tx;

  // Receive-side stand-in: returns sync_din three edges later.
  always @(posedge clk_tx) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[1:0], bus.sync_din};
  end

  assign bus.sync_ack = ack_auto ? pipe[2] : ack_man;

  task automatic step();
    @(posedge clk_tx);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int limit, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (bus.grant == '0 && cnt < limit);
  endtask

  task automatic wait_idle(input int limit, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (bus.busy !== 1'b0 && cnt < limit);
  endtask

  initial begin
    int         order [6];
    logic [7:0] dat [4];
    logic [3:0] g_exp;

    order = '{0, 1, 2, 3, 0, 1};
    dat   = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
    total = 0;
    bad   = 0;

    rst          = 1'b1;
    ack_auto     = 1'b1;
    ack_man      = 1'b0;
    bus.req      = '0;
    bus.req_data = {8'hC3, 8'h3C, 8'h5A, 8'hA5};
    bus.err_clr  = 1'b0;

    // Reset values.
    step();
    step();
    check("rst_grant", bus.grant, 4'b0000);
    check("rst_din", bus.sync_din, 1'b0);
    check("rst_data", bus.tx_data, 8'h00);
    check("rst_id", bus.tx_id, 2'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_err", bus.err_timeout, 1'b0);

    // Single transfer from requester 0, ack returned after three cycles.
    rst     = 1'b0;
    bus.req = 4'b0001;
    step();
    check("t1_grant", bus.grant, 4'b0001);
    check("t1_din", bus.sync_din, 1'b1);
    check("t1_data", bus.tx_data, 8'hA5);
    check("t1_id", bus.tx_id, 2'd0);
    check("t1_busy", bus.busy, 1'b1);
    bus.req = '0;
    step();
    check("t1_grant_pulse", bus.grant, 4'b0000);
    step();
    step();
    check("t1_data_held", bus.tx_data, 8'hA5);
    check("t1_din_held", bus.sync_din, 1'b1);
    step();
    step();
    step();
    check("t1_busy_gap", bus.busy, 1'b1);
    step();
    check("t1_busy_fall", bus.busy, 1'b0);

    // All four requesting: strict rotation from pointer 0.
    rst = 1'b1;
    step();
    rst     = 1'b0;
    bus.req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_grant(20, n);
      g_exp = 4'b0001 << order[k];
      check($sformatf("t2_lat%0d", k), n, (k == 0) ? 1 : 8);
      check($sformatf("t2_grant%0d", k), bus.grant, g_exp);
      check($sformatf("t2_id%0d", k), bus.tx_id, order[k]);
      check($sformatf("t2_din%0d", k), bus.sync_din, (k % 2 == 0) ? 1 : 0);
      check($sformatf("t2_data%0d", k), bus.tx_data, dat[order[k]]);
    end

    // Pointer sits at 2 after granting 1; two low requesters wrap to 0 then 1.
    bus.req = 4'b0011;
    wait_grant(20, n);
    check("t3_lat0", n, 8);
    check("t3_grant0", bus.grant, 4'b0001);
    check("t3_data0", bus.tx_data, 8'hA5);
    wait_grant(20, n);
    check("t3_lat1", n, 8);
    check("t3_grant1", bus.grant, 4'b0010);
    check("t3_data1", bus.tx_data, 8'h5A);
    bus.req = '0;
    wait_idle(20, n);
    check("t3_idle", n, 7);

    // No ack: timeout fires 64 cycles after the toggle.
    ack_man  = 1'b0;
    ack_auto = 1'b0;
    bus.req  = 4'b0100;
    wait_grant(20, n);
    check("t4_lat", n, 1);
    check("t4_grant", bus.grant, 4'b0100);
    check("t4_din", bus.sync_din, 1'b1);
    bus.req = '0;
    repeat (63) step();
    check("t4_err_early", bus.err_timeout, 1'b0);
    check("t4_din_early", bus.sync_din, 1'b1);
    step();
    check("t4_err_set", bus.err_timeout, 1'b1);
    check("t4_din_revert", bus.sync_din, 1'b0);
    check("t4_busy", bus.busy, 1'b1);
    wait_idle(20, n);
    check("t4_idle", n, 3);

    // Next transfer completes normally with the error still flagged.
    ack_auto = 1'b1;
    bus.req  = 4'b1000;
    wait_grant(20, n);
    check("t4b_lat", n, 1);
    check("t4b_id", bus.tx_id, 2'd3);
    check("t4b_data", bus.tx_data, 8'hC3);
    check("t4b_din", bus.sync_din, 1'b1);
    bus.req = '0;
    wait_idle(20, n);
    check("t4b_idle", n, 7);
    check("t4b_err_sticky", bus.err_timeout, 1'b1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("t4b_err_clr", bus.err_timeout, 1'b0);

    // Ack lands in the very cycle the timeout would fire.
    ack_man  = 1'b1;
    ack_auto = 1'b0;
    bus.req  = 4'b0001;
    wait_grant(20, n);
    check("t5_id", bus.tx_id, 2'd0);
    check("t5_din", bus.sync_din, 1'b0);
    bus.req = '0;
    repeat (63) step();
    check("t5_err_early", bus.err_timeout, 1'b0);
    ack_man = 1'b0;
    step();
    check("t5_err", bus.err_timeout, 1'b0);
    check("t5_busy", bus.busy, 1'b1);
    wait_idle(20, n);
    check("t5_idle", n, 3);
    check("t5_err_after", bus.err_timeout, 1'b0);

    // Reset in the middle of WAIT_ACK with sync_din high.
    bus.req = 4'b0010;
    wait_grant(20, n);
    check("t6_id", bus.tx_id, 2'd1);
    check("t6_din", bus.sync_din, 1'b1);
    bus.req = '0;
    step();
    step();
    rst     = 1'b1;
    bus.req = 4'b0110;
    step();
    check("t6_rst_din", bus.sync_din, 1'b0);
    check("t6_rst_busy", bus.busy, 1'b0);
    check("t6_rst_grant", bus.grant, 4'b0000);
    check("t6_rst_id", bus.tx_id, 2'd0);
    rst = 1'b0;
    step();
    check("t6_regrant", bus.grant, 4'b0010);
    check("t6_regrant_id", bus.tx_id, 2'd1);
    check("t6_regrant_din", bus.sync_din, 1'b1);
    bus.req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
